// File: rtl/lock_pkg.sv
// -----------------------------------------------------------------------------
// lock_pkg
// Shared definitions for the keypad entry controller: the FSM state type,
// BCD and code widths, and the bit layout of the 12-bit key vector
// (digits 0..9 in bits 0..9, enter in bit 10, clear in bit 11).
// -----------------------------------------------------------------------------
package lock_pkg;

    localparam int BCD_W      = 4;
    localparam int CODE_W     = 32;
    localparam int KEY_W      = 12;
    localparam int DIGIT_KEYS = 10;
    localparam int ENTER_BIT  = 10;
    localparam int CLEAR_BIT  = 11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENTRY  = 2'd1,
        ST_SUBMIT = 2'd2
    } state_t;

    // BCD value of the lowest set digit key; only meaningful when exactly
    // one digit key is set.
    function automatic logic [BCD_W-1:0] digit_of(input logic [DIGIT_KEYS-1:0] keys);
        logic [BCD_W-1:0] d;
        d = '0;
        for (int i = DIGIT_KEYS - 1; i >= 0; i--) begin
            if (keys[i]) d = i[BCD_W-1:0];
        end
        return d;
    endfunction

    // Number of digit keys set, used to reject multi-digit chords.
    function automatic logic [3:0] digit_count(input logic [DIGIT_KEYS-1:0] keys);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < DIGIT_KEYS; i++) begin
            n = n + {3'b000, keys[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Two-flop synchronizer followed by a stability filter. The filtered output
// follows the synchronized vector only after it has held the same value for
// DEBOUNCE_CYCLES consecutive samples; any change restarts the count.
//
// Ports:
//   clk     clock
//   rst     asynchronous active-low reset
//   raw     asynchronous, bouncing key inputs
//   stable  debounced key vector
// -----------------------------------------------------------------------------
module key_debounce #(
    parameter int WIDTH           = 12,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] stable
);

    localparam logic [7:0] LAST_COUNT = 8'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] candidate;
    logic [7:0]       stable_cnt;

    // The first sample of a new value loads the candidate with a count of one;
    // the filtered output is committed on the sample that completes the run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1      <= '0;
            sync2      <= '0;
            candidate  <= '0;
            stable_cnt <= '0;
            stable     <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 != candidate) begin
                candidate  <= sync2;
                stable_cnt <= 8'd1;
            end else if (stable_cnt == LAST_COUNT) begin
                stable <= candidate;
            end else begin
                stable_cnt <= stable_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// -----------------------------------------------------------------------------
// keypad_entry_ctrl
// Collects debounced BCD digits from a keypad into a shift buffer and hands
// the finished code to a downstream comparator with a valid/ready handshake.
//
// Ports:
//   clk         clock
//   rst         asynchronous active-low reset
//   key_in      raw one-hot digit keys (bit i = digit i)
//   enter_in    raw submit key
//   clear_in    raw clear key
//   code_ready  downstream accepts the code this cycle
//   code_out    packed BCD entry, newest digit in [3:0]
//   code_len    number of valid digits in code_out
//   code_valid  submitted code held stable for downstream
//   entry_busy  high while in ENTRY or SUBMIT
//   key_err     one-cycle pulse on a rejected key event
// -----------------------------------------------------------------------------
module keypad_entry_ctrl
    import lock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_DIGITS      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        key_in,
    input  logic              enter_in,
    input  logic              clear_in,
    input  logic              code_ready,
    output logic [CODE_W-1:0] code_out,
    output logic [3:0]        code_len,
    output logic              code_valid,
    output logic              entry_busy,
    output logic              key_err
);

    localparam logic [3:0] MAX_LEN = 4'(MAX_DIGITS);

    logic [KEY_W-1:0]  raw_keys;
    logic [KEY_W-1:0]  deb_keys;
    logic [KEY_W-1:0]  deb_prev;
    logic              key_event;
    logic              ev_clear;
    logic              ev_enter;
    logic              ev_multi;
    logic [BCD_W-1:0]  ev_digit;

    state_t            state;
    state_t            state_next;
    logic [CODE_W-1:0] code_next;
    logic [3:0]        len_next;
    logic              err_next;

    assign raw_keys = {clear_in, enter_in, key_in};

    key_debounce #(
        .WIDTH           (KEY_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .raw    (raw_keys),
        .stable (deb_keys)
    );

    // An event is only the release-to-press transition of the debounced
    // vector, so chord changes while keys stay down never fire twice.
    assign key_event = (deb_keys != '0) && (deb_prev == '0);
    assign ev_clear  = deb_keys[CLEAR_BIT];
    assign ev_enter  = deb_keys[ENTER_BIT];
    assign ev_multi  = digit_count(deb_keys[DIGIT_KEYS-1:0]) > 4'd1;
    assign ev_digit  = digit_of(deb_keys[DIGIT_KEYS-1:0]);

    assign code_valid = (state == ST_SUBMIT);
    assign entry_busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            code_out <= '0;
            code_len <= '0;
            key_err  <= 1'b0;
            deb_prev <= '0;
        end else begin
            state    <= state_next;
            code_out <= code_next;
            code_len <= len_next;
            key_err  <= err_next;
            deb_prev <= deb_keys;
        end
    end

    // Key priority is clear, then enter, then digits. The buffer never holds
    // more than MAX_DIGITS nibbles, so upper nibbles stay zero on their own.
    always_comb begin
        state_next = state;
        code_next  = code_out;
        len_next   = code_len;
        err_next   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (key_event) begin
                    if (ev_clear) begin
                        state_next = ST_IDLE;
                    end else if (ev_enter || ev_multi) begin
                        err_next = 1'b1;
                    end else begin
                        code_next  = {{(CODE_W-BCD_W){1'b0}}, ev_digit};
                        len_next   = 4'd1;
                        state_next = ST_ENTRY;
                    end
                end
            end
            ST_ENTRY: begin
                if (key_event) begin
                    if (ev_clear) begin
                        code_next  = '0;
                        len_next   = '0;
                        state_next = ST_IDLE;
                    end else if (ev_enter) begin
                        state_next = ST_SUBMIT;
                    end else if (ev_multi || (code_len >= MAX_LEN)) begin
                        err_next = 1'b1;
                    end else begin
                        code_next = {code_out[CODE_W-BCD_W-1:0], ev_digit};
                        len_next  = code_len + 4'd1;
                    end
                end
            end
            ST_SUBMIT: begin
                if (code_ready) begin
                    code_next  = '0;
                    len_next   = '0;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                code_next  = '0;
                len_next   = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// -----------------------------------------------------------------------------
// tb_keypad_entry_ctrl
// Self-checking bench for keypad_entry_ctrl: directed scenarios followed by
// random key events, compared against an event-level model of the entry
// buffer (a queue of digits plus a submitted flag).
// -----------------------------------------------------------------------------
module tb_keypad_entry_ctrl;

    localparam int D    = 4;
    localparam int MAXD = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  key_in;
    logic        enter_in;
    logic        clear_in;
    logic        code_ready;
    logic [31:0] code_out;
    logic [3:0]  code_len;
    logic        code_valid;
    logic        entry_busy;
    logic        key_err;

    int n_cmp = 0;
    int n_bad = 0;
    int err_seen = 0;

    int digs[$];
    bit sub;
    int err_exp = 0;

    keypad_entry_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .MAX_DIGITS      (MAXD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .enter_in   (enter_in),
        .clear_in   (clear_in),
        .code_ready (code_ready),
        .code_out   (code_out),
        .code_len   (code_len),
        .code_valid (code_valid),
        .entry_busy (entry_busy),
        .key_err    (key_err)
    );

    always #5 clk = ~clk;

    // Every cycle key_err is high counts once, so a stretched pulse shows up
    // as an extra error.
    always @(negedge clk) begin
        if (key_err === 1'b1) err_seen++;
    end

    function automatic logic [11:0] dig(input int d);
        logic [11:0] one;
        one = 12'd1;
        return one << d;
    endfunction

    function automatic logic [31:0] model_code();
        logic [31:0] c;
        c = 32'd0;
        foreach (digs[i]) c = (c * 32'd16) + 32'(digs[i]);
        return c;
    endfunction

    task automatic model_reset();
        digs.delete();
        sub = 1'b0;
    endtask

    // Event rules: clear > enter > digit, SUBMIT ignores keys, a full buffer
    // or a multi-digit chord is rejected.
    task automatic model_event(input logic [11:0] v);
        int nd;
        nd = $countones(v[9:0]);
        if (sub) return;
        if (v[11]) begin
            digs.delete();
        end else if (v[10]) begin
            if (digs.size() == 0) err_exp++;
            else sub = 1'b1;
        end else if (nd > 1) begin
            err_exp++;
        end else if (digs.size() >= MAXD) begin
            err_exp++;
        end else begin
            for (int i = 0; i < 10; i++) if (v[i]) digs.push_back(i);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, " code_out"}, code_out, model_code());
        checkOutput({tag, " code_len"}, {28'd0, code_len}, 32'(digs.size()));
        checkOutput({tag, " code_valid"}, {31'd0, code_valid}, {31'd0, sub});
        checkOutput({tag, " entry_busy"}, {31'd0, entry_busy},
                    {31'd0, (sub || digs.size() != 0)});
        checkOutput({tag, " key_err count"}, 32'(err_seen), 32'(err_exp));
    endtask

    task automatic set_keys(input logic [11:0] v);
        key_in   = v[9:0];
        enter_in = v[10];
        clear_in = v[11];
    endtask

    // Clean press long enough to debounce, then a clean release.
    task automatic applyStimulus(input logic [11:0] v);
        @(negedge clk);
        set_keys(v);
        repeat (D + 8) @(negedge clk);
        set_keys(12'd0);
        repeat (D + 8) @(negedge clk);
        model_event(v);
    endtask

    task automatic handshake();
        @(negedge clk);
        code_ready = 1'b1;
        @(negedge clk);
        code_ready = 1'b0;
        if (sub) model_reset();
    endtask

    // Counts rising edges until code_len moves; gives up after 40 edges.
    task automatic measure_latency(output int lat);
        logic [3:0] old;
        old = code_len;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (code_len !== old) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic settle_release();
        repeat (D + 6) @(negedge clk);
        set_keys(12'd0);
        repeat (D + 8) @(negedge clk);
    endtask

    initial begin
        int lat;
        int r;
        int a;
        int b;
        logic [11:0] v;

        rst = 1'b0;
        code_ready = 1'b0;
        set_keys(12'd0);
        model_reset();
        repeat (3) @(negedge clk);
        checkAll("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Digits 1..4 then enter; latency measured on the first digit.
        @(negedge clk);
        set_keys(dig(1));
        measure_latency(lat);
        checkOutput("latency digit 1", 32'(lat), 32'(D + 3));
        settle_release();
        model_event(dig(1));
        applyStimulus(dig(2));
        applyStimulus(dig(3));
        applyStimulus(dig(4));
        applyStimulus(dig(10));
        checkOutput("submit code", code_out, 32'h0000_1234);
        checkAll("submit 1234");
        repeat (5) @(negedge clk);
        checkAll("submit held");
        handshake();
        checkAll("after handshake");

        // Key 5 bouncing for three cycles before settling.
        @(negedge clk); set_keys(dig(5));
        @(negedge clk); set_keys(12'd0);
        @(negedge clk); set_keys(dig(5));
        @(negedge clk); set_keys(12'd0);
        @(negedge clk); set_keys(dig(5));
        measure_latency(lat);
        checkOutput("latency bounce", 32'(lat), 32'(D + 3));
        settle_release();
        model_event(dig(5));
        checkOutput("bounce code", code_out, 32'h5);
        checkAll("bounce");
        applyStimulus(dig(11));
        checkAll("clear after bounce");

        // Nine digits overflow an eight-digit buffer.
        for (int d = 1; d <= 9; d++) applyStimulus(dig(d));
        checkOutput("full code", code_out, 32'h1234_5678);
        checkAll("overflow");

        // Multi-digit chord, then clear+enter together.
        applyStimulus(dig(3) | dig(7));
        checkAll("chord 3+7");
        applyStimulus(dig(10) | dig(11));
        checkAll("clear+enter");

        // code_ready outside SUBMIT.
        applyStimulus(dig(6));
        handshake();
        checkAll("stray ready");
        applyStimulus(dig(11));

        // Reset during SUBMIT drops everything immediately.
        applyStimulus(dig(9));
        applyStimulus(dig(8));
        applyStimulus(dig(10));
        checkAll("pre-reset submit");
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_reset();
        checkAll("async reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        applyStimulus(dig(10));
        checkAll("enter in idle");

        // Key held across reset needs a full debounce after release.
        @(negedge clk);
        set_keys(dig(2));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
        measure_latency(lat);
        checkOutput("latency after reset", 32'(lat), 32'(D + 3));
        settle_release();
        model_event(dig(2));
        checkAll("held through reset");

        // Random events.
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 5) begin
                v = dig($urandom_range(0, 9));
            end else if (r == 6) begin
                v = dig(10);
            end else if (r == 7) begin
                v = dig(11);
            end else if (r == 8) begin
                a = $urandom_range(0, 9);
                b = (a + $urandom_range(1, 9)) % 10;
                v = dig(a) | dig(b);
            end else begin
                v = 12'($urandom_range(1, 4095));
            end
            applyStimulus(v);
            if ($urandom_range(0, 9) < 3) handshake();
            checkAll("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
